adder_tree_arbiter: RTL and testbench

- Shares one external pipelined 5-operand adder tree between NUM_REQ requesters.
- Each requester presents five operands (A..E). The block grants requesters round-robin and drives the tree's operand inputs.
- An ID tag travels alongside each issue through a fixed-latency tag pipeline. The tree sum and its requester ID return through a credit-protected result FIFO with valid/ready backpressure.

---
 rtl/adder_tree_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_adder_tree_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
// adder_tree_arbiter : round-robin, credit-protected sharing of one external
// pipelined 5-operand adder tree. Optional statistics: ADDER_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
module adder_tree_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int TREE_LAT   = 3,
  parameter int E_SKEW     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*5*WIDTH-1:0]   req_data,
  output logic [WIDTH-1:0]             tree_a,
  output logic [WIDTH-1:0]             tree_b,
  output logic [WIDTH-1:0]             tree_c,
  output logic [WIDTH-1:0]             tree_d,
  output logic [WIDTH-1:0]             tree_e,
  input  logic [WIDTH-1:0]             tree_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_data
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        grant_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int IDW1 = IDW + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int OPW  = 5 * WIDTH;
  localparam int EW   = IDW + WIDTH;

  logic [IDW-1:0]     r_ptr;
  logic [CW-1:0]      r_outstanding;
  logic               w_credit_ok;
  logic               w_found;
  logic               w_fire;
  logic               w_pop;
  logic               w_push;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW1-1:0]    w_idx;
  logic [OPW-1:0]     w_ops;

  // Credit counts tags in flight plus FIFO entries, so every issue has a slot.
  assign w_credit_ok = (r_outstanding < CW'(FIFO_DEPTH));

  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + IDW1'(i);
      if (w_idx >= IDW1'(NUM_REQ)) w_idx = w_idx - IDW1'(NUM_REQ);
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
    if (w_found) w_grant[w_gnt_id] = 1'b1;
  end

  assign req_ready = (rst_n && w_credit_ok) ? w_grant : '0;
  assign w_fire    = |req_ready;
  assign w_ops     = req_data[w_gnt_id*OPW +: OPW];
  assign w_pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_fire, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_a <= '0;
      tree_b <= '0;
      tree_c <= '0;
      tree_d <= '0;
    end else if (w_fire) begin
      tree_a <= w_ops[0*WIDTH +: WIDTH];
      tree_b <= w_ops[1*WIDTH +: WIDTH];
      tree_c <= w_ops[2*WIDTH +: WIDTH];
      tree_d <= w_ops[3*WIDTH +: WIDTH];
    end
  end

  generate
    if (E_SKEW == 0) begin : g_e_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tree_e <= '0;
        else if (w_fire) tree_e <= w_ops[4*WIDTH +: WIDTH];
      end
    end else begin : g_e_skew
      // E travels with its own valid so tree_e holds while idle.
      logic [E_SKEW-1:0][WIDTH-1:0] r_e_dly;
      logic [E_SKEW-1:0]            r_e_vld;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_e_dly <= '0;
          r_e_vld <= '0;
          tree_e  <= '0;
        end else begin
          r_e_vld[0] <= w_fire;
          r_e_dly[0] <= w_ops[4*WIDTH +: WIDTH];
          for (int j = 1; j < E_SKEW; j++) begin
            r_e_vld[j] <= r_e_vld[j-1];
            r_e_dly[j] <= r_e_dly[j-1];
          end
          if (r_e_vld[E_SKEW-1]) tree_e <= r_e_dly[E_SKEW-1];
        end
      end
    end
  endgenerate

  logic [TREE_LAT:0]          r_tag_vld;
  logic [TREE_LAT:0][IDW-1:0] r_tag_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[TREE_LAT-1:0], w_fire};
      r_tag_id  <= {r_tag_id[TREE_LAT-1:0], w_gnt_id};
    end
  end

  assign w_push = r_tag_vld[TREE_LAT];

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_tag_id[TREE_LAT], tree_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid          = (r_count != '0);
  assign {rsp_id, rsp_data} = rsp_valid ? r_mem[r_rd_ptr] : '0;

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_ready[r]) grant_cnt[r*16 +: 16] <= grant_cnt[r*16 +: 16] + 16'd1;
      end
      if ((|req_valid) && !w_credit_ok && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder_tree_arbiter : randomized self-checking bench with a queue-based
// reference model and a behavioural model of the external adder tree.
// Revision: 1.0
// ============================================================================
module tb_adder_tree_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int WIDTH      = 16;
  localparam int TREE_LAT   = 3;
  localparam int E_SKEW     = 1;
  localparam int FIFO_DEPTH = 8;
  localparam int IDW        = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*5*WIDTH-1:0] req_data;
  logic [WIDTH-1:0]           tree_a, tree_b, tree_c, tree_d, tree_e, tree_out;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_data;
`ifdef ADDER_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]      grant_cnt;
  logic [15:0]                stall_cnt;
  int                         gsum;
`endif

  always #5 clk = ~clk;

  adder_tree_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TREE_LAT(TREE_LAT),
    .E_SKEW(E_SKEW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .tree_a(tree_a), .tree_b(tree_b), .tree_c(tree_c), .tree_d(tree_d), .tree_e(tree_e),
    .tree_out(tree_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ADDER_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // External tree: sum of A..D from TREE_LAT edges ago plus the matching skewed E.
  logic [WIDTH-1:0] abcd_h [TREE_LAT];
  logic [WIDTH-1:0] e_h    [TREE_LAT];
  always @(posedge clk) begin
    abcd_h[0] <= tree_a + tree_b + tree_c + tree_d;
    e_h[0]    <= tree_e;
    for (int j = 1; j < TREE_LAT; j++) begin
      abcd_h[j] <= abcd_h[j-1];
      e_h[j]    <= e_h[j-1];
    end
  end
  assign tree_out = abcd_h[TREE_LAT-1] + e_h[TREE_LAT-1-E_SKEW];

  typedef struct { int id; logic [WIDTH-1:0] sum; int due; } flight_t;
  typedef struct { int id; logic [WIDTH-1:0] sum; } rsp_t;
  typedef struct { logic [WIDTH-1:0] val; int due; } epend_t;

  flight_t          flight_q[$];
  rsp_t             fifo_q[$];
  epend_t           e_q[$];
  int               m_ptr, m_out, edge_no;
  logic [WIDTH-1:0] m_a, m_b, m_c, m_d, m_e;
  int               checks, errors, dut_hs;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] op(input int r, input int k);
    return req_data[(r*5 + k)*WIDTH +: WIDTH];
  endfunction

  function automatic int model_grant();
    if (m_out >= FIFO_DEPTH) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int r;
      r = (m_ptr + i) % NUM_REQ;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    flight_q.delete();
    fifo_q.delete();
    e_q.delete();
    m_ptr = 0;
    m_out = 0;
    m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_e = '0;
  endtask

  task automatic set_ops(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] e);
    req_data[r*5*WIDTH +: 5*WIDTH] = {e, d, c, b, a};
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ*5; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // One clock cycle: compare at the falling edge, advance the model for the rising edge.
  task automatic step();
    int                 g;
    logic               pop;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH-1:0]   s;
    flight_t            f;
    epend_t             ep;
    rsp_t               rr;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, fifo_q.size() != 0);
    check("fifo_occupancy", dut.r_count, fifo_q.size());
    if (fifo_q.size() != 0) begin
      check("rsp_id", rsp_id, fifo_q[0].id);
      check("rsp_data", rsp_data, fifo_q[0].sum);
    end
    check("tree_a", tree_a, m_a);
    check("tree_b", tree_b, m_b);
    check("tree_c", tree_c, m_c);
    check("tree_d", tree_d, m_d);
    check("tree_e", tree_e, m_e);
    if ((req_ready & req_valid) != '0) dut_hs++;
    pop = rsp_ready && (fifo_q.size() != 0);

    edge_no++;
    if (pop) begin
      void'(fifo_q.pop_front());
      m_out--;
    end
    while (flight_q.size() != 0 && flight_q[0].due == edge_no) begin
      rr.id  = flight_q[0].id;
      rr.sum = flight_q[0].sum;
      fifo_q.push_back(rr);
      void'(flight_q.pop_front());
    end
    while (e_q.size() != 0 && e_q[0].due == edge_no) begin
      m_e = e_q[0].val;
      void'(e_q.pop_front());
    end
    if (g >= 0) begin
      m_a = op(g, 0); m_b = op(g, 1); m_c = op(g, 2); m_d = op(g, 3);
      s = op(g, 0) + op(g, 1) + op(g, 2) + op(g, 3) + op(g, 4);
      f.id = g; f.sum = s; f.due = edge_no + TREE_LAT + 1;
      flight_q.push_back(f);
      m_out++;
      m_ptr = (g + 1) % NUM_REQ;
      if (E_SKEW == 0) m_e = op(g, 4);
      else begin
        ep.val = op(g, 4); ep.due = edge_no + E_SKEW;
        e_q.push_back(ep);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asserted just after a rising edge; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst tree_a", tree_a, 0);
    check("rst tree_b", tree_b, 0);
    check("rst tree_c", tree_c, 0);
    check("rst tree_d", tree_d, 0);
    check("rst tree_e", tree_e, 0);
    check("rst req_ready", req_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_id", rsp_id, 0);
    check("rst rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; edge_no = 0; dut_hs = 0;
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; req_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();
    req_valid = '0;
    repeat (3) step();

    // Single request from requester 2
    rand_data();
    set_ops(2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    check("single tree_a", tree_a, 1);
    check("single tree_d", tree_d, 4);
    repeat (TREE_LAT + 1) step();
    check("single rsp_valid", rsp_valid, 1);
    check("single rsp_id", rsp_id, 2);
    check("single rsp_data", rsp_data, 15);
    rsp_ready = 1'b1;
    repeat (2) step();

    // Wrap-around sum from requester 0
    set_ops(0, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (TREE_LAT + 1) step();
    check("wrap rsp_valid", rsp_valid, 1);
    check("wrap rsp_id", rsp_id, 0);
    check("wrap rsp_data", rsp_data, 0);
    repeat (2) step();

    // Round-robin with every requester valid
    req_valid = '1;
    repeat (24) begin
      rand_data();
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // Backpressure from a clean reset
    apply_reset();
    dut_hs = 0;
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (20) begin
      rand_data();
      step();
    end
    check("bp handshakes", dut_hs, 8);
    check("bp fifo full", dut.r_count, 8);
    check("bp stalled", req_ready, 0);
`ifdef ADDER_ARB_STATS_EN
    gsum = 0;
    for (int r = 0; r < NUM_REQ; r++) gsum += int'(grant_cnt[r*16 +: 16]);
    check("stats grant_sum", gsum, 8);
    check("stats stall_cnt", stall_cnt, 12);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    dut_hs = 0;
    repeat (3) step();
    check("bp single refill", dut_hs, 1);
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (20) step();

    // Random traffic, first with heavy then light backpressure
    for (int n = 0; n < 400; n++) begin
      req_valid = NUM_REQ'($urandom);
      rsp_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) step();

    // Reset with tags in flight and one entry already in the FIFO
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (3) begin
      rand_data();
      step();
    end
    req_valid = '0;
    repeat (2) step();
    apply_reset();
    rsp_ready = 1'b1;
    repeat (10) step();
    req_valid = '1;
    #1;
    check("post-reset grant", req_ready, 4'b0001);
    repeat (4) step();
    req_valid = '0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
